wb_writer: RTL and testbench



---
 rtl/wb_writer.sv | 126 ++++++++++++
 tb/tb_wb_writer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_writer.sv
// Register-file write-back sequencer: arbitrates the ALU path against a
// 2-deep mult/div result FIFO and tracks destinations owed by in-flight
// mult/div operations.
module wb_writer (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_rd,
    output logic        wb_stall,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic [31:0] pend_mask
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 2;

    logic [REG_W-1:0]  fifo_rd   [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic              wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              push, pop;
    logic [REG_W-1:0]  head_rd;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  count_n;
    logic              we_n;
    logic [REG_W-1:0]  wreg_n;
    logic [DATA_W-1:0] wdata_n;
    logic [31:0]       pend_n;

    // Flow-control flags derive only from the occupancy register
    assign md_ready = (count != CNT_W'(DEPTH));
    assign wb_stall = (count == CNT_W'(DEPTH));

    assign head_rd   = fifo_rd[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // Port arbitration (ALU first, then FIFO head), occupancy and scoreboard next-state
    always_comb begin
        push    = md_valid && md_ready;
        pop     = 1'b0;
        we_n    = 1'b0;
        wreg_n  = ctrl_writeReg;
        wdata_n = data_writeReg;
        pend_n  = pend_mask;

        if (alu_valid) begin
            if (alu_rd != '0) begin
                we_n    = 1'b1;
                wreg_n  = alu_rd;
                wdata_n = alu_data;
            end
        end else if (count != '0) begin
            pop = 1'b1;
            if (head_rd != '0) begin
                we_n    = 1'b1;
                wreg_n  = head_rd;
                wdata_n = head_data;
                pend_n[head_rd] = 1'b0;
            end
        end

        // A new issue to the same register supersedes a same-cycle clear
        if (md_issue && (md_issue_rd != '0)) begin
            pend_n[md_issue_rd] = 1'b1;
        end
        pend_n[0] = 1'b0;

        count_n = count;
        if (push && !pop) begin
            count_n = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_n = count - CNT_W'(1);
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= '0;
            fifo_rd[0]   <= '0;
            fifo_rd[1]   <= '0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
        end else begin
            if (push) begin
                fifo_rd[wr_ptr]   <= md_rd;
                fifo_data[wr_ptr] <= md_data;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_n;
        end
    end

    // Registered write port and pending-destination scoreboard
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
            pend_mask        <= '0;
        end else begin
            ctrl_writeEnable <= we_n;
            ctrl_writeReg    <= wreg_n;
            data_writeReg    <= wdata_n;
            pend_mask        <= pend_n;
        end
    end

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer with a behavioural register file on the write port.
module tb_wb_writer;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        wb_stall;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] pend_mask;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] rf [32];

    wb_writer dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .alu_valid        (alu_valid),
        .alu_rd           (alu_rd),
        .alu_data         (alu_data),
        .md_valid         (md_valid),
        .md_ready         (md_ready),
        .md_rd            (md_rd),
        .md_data          (md_data),
        .md_issue         (md_issue),
        .md_issue_rd      (md_issue_rd),
        .wb_stall         (wb_stall),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .pend_mask        (pend_mask)
    );

    always #5 clock = ~clock;

    // Register file model fed by the write port
    always @(posedge clock) begin
        if (ctrl_writeEnable) rf[ctrl_writeReg] <= data_writeReg;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        md_valid  = 1'b0; md_rd  = '0; md_data  = '0;
        md_issue  = 1'b0; md_issue_rd = '0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    endtask

    task automatic md(input logic [4:0] rd, input logic [31:0] d);
        md_valid = 1'b1; md_rd = rd; md_data = d;
    endtask

    task automatic port(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
        check({tag, ".we"}, 32'(ctrl_writeEnable), 32'(we));
        check({tag, ".reg"}, 32'(ctrl_writeReg), 32'(rd));
        check({tag, ".data"}, data_writeReg, d);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        idle();
        ctrl_reset_n = 1'b0;
        tick(); tick();
        port("reset", 1'b0, 5'd0, 32'h0);
        check("reset.pend", pend_mask, 32'h0);
        check("reset.ready", 32'(md_ready), 32'd1);
        check("reset.stall", 32'(wb_stall), 32'd0);
        ctrl_reset_n = 1'b1;
        tick();

        // ALU only
        alu(5'd5, 32'hDEADBEEF); tick();
        port("alu.c2", 1'b1, 5'd5, 32'hDEADBEEF);
        idle(); tick();
        port("alu.c3", 1'b0, 5'd5, 32'hDEADBEEF);
        check("alu.rf5", rf[5], 32'hDEADBEEF);

        // Collision: ALU delays the FIFO head
        md(5'd7, 32'd3); tick();
        idle(); alu(5'd8, 32'd1); tick();
        port("col.c3", 1'b1, 5'd8, 32'd1);
        alu(5'd9, 32'd2); tick();
        port("col.c4", 1'b1, 5'd9, 32'd2);
        idle(); tick();
        port("col.c5", 1'b1, 5'd7, 32'd3);
        tick();
        check("col.idle.we", 32'(ctrl_writeEnable), 32'd0);

        // FIFO full while ALU holds the port
        alu(5'd10, 32'h10); md(5'd11, 32'h11); tick();
        alu(5'd13, 32'h13); md(5'd14, 32'h14); tick();
        port("full.alu", 1'b1, 5'd13, 32'h13);
        check("full.ready", 32'(md_ready), 32'd0);
        check("full.stall", 32'(wb_stall), 32'd1);
        idle(); tick();
        port("full.e0", 1'b1, 5'd11, 32'h11);
        check("full.e0.ready", 32'(md_ready), 32'd1);
        check("full.e0.stall", 32'(wb_stall), 32'd0);
        tick();
        port("full.e1", 1'b1, 5'd14, 32'h14);
        tick();
        check("full.drain.we", 32'(ctrl_writeEnable), 32'd0);
        check("full.drain.ready", 32'(md_ready), 32'd1);

        // r0 discard on both paths
        alu(5'd0, 32'h55); tick();
        port("r0.alu", 1'b0, 5'd14, 32'h14);
        idle(); md(5'd0, 32'h66); tick();
        idle(); tick();
        port("r0.md", 1'b0, 5'd14, 32'h14);
        md(5'd3, 32'h33); tick();
        idle(); tick();
        port("r0.next", 1'b1, 5'd3, 32'h33);
        tick();
        check("r0.rf0", rf[0], 32'h0);

        // Scoreboard set, then clear on pop
        md_issue = 1'b1; md_issue_rd = 5'd12; tick();
        idle();
        check("sb.set", pend_mask, 32'h0000_1000);
        tick(); tick();
        md(5'd12, 32'hC); tick();
        idle(); tick();
        port("sb.pop", 1'b1, 5'd12, 32'hC);
        check("sb.clear", pend_mask, 32'h0);

        // Re-issue in the pop cycle: set wins
        md_issue = 1'b1; md_issue_rd = 5'd12; tick();
        idle(); tick();
        md(5'd12, 32'hD); tick();
        idle(); md_issue = 1'b1; md_issue_rd = 5'd12; tick();
        idle();
        port("sb.reissue.port", 1'b1, 5'd12, 32'hD);
        check("sb.setwins", pend_mask, 32'h0000_1000);
        md(5'd12, 32'hE); md_issue = 1'b1; md_issue_rd = 5'd7; tick();
        idle();
        check("sb.two", pend_mask, 32'h0000_1080);
        tick();
        check("sb.indep", pend_mask, 32'h0000_0080);
        md_issue = 1'b1; md_issue_rd = 5'd0; tick();
        idle();
        check("sb.r0", pend_mask, 32'h0000_0080);

        // Reset mid-operation with a full FIFO
        md_issue = 1'b1; md_issue_rd = 5'd12; alu(5'd20, 32'h20); md(5'd7, 32'h77); tick();
        idle(); alu(5'd21, 32'h21); md(5'd12, 32'h78); tick();
        idle();
        check("rst.pre.pend", pend_mask, 32'h0000_1080);
        check("rst.pre.stall", 32'(wb_stall), 32'd1);
        #2 ctrl_reset_n = 1'b0;
        #1;
        port("rst.async", 1'b0, 5'd0, 32'h0);
        check("rst.async.pend", pend_mask, 32'h0);
        check("rst.async.ready", 32'(md_ready), 32'd1);
        check("rst.async.stall", 32'(wb_stall), 32'd0);
        #1 ctrl_reset_n = 1'b1;
        tick();
        port("rst.after1", 1'b0, 5'd0, 32'h0);
        tick();
        port("rst.after2", 1'b0, 5'd0, 32'h0);
        check("rst.after.pend", pend_mask, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
